// File: rtl/hazard_ctrl_mc_if.sv
// Pipeline-to-hazard-controller signal bundle: register IDs and control bits in,
// stall, flush and forward selects out.
interface hazard_ctrl_mc_if #(
  parameter int unsigned CNT_W = 16
);
  logic [4:0]       Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic             ResultSrcE0, RegWriteM, RegWriteW, PCSrcE, FpMultiE;
  logic             StallF, StallD, StallE, FlushD, FlushE, FlushM;
  logic [1:0]       ForwardAE, ForwardBE;
  logic             FpBusy, FpDoneE;
  logic [CNT_W-1:0] StallCnt;

  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    output ResultSrcE0, RegWriteM, RegWriteW, PCSrcE, FpMultiE,
    input  StallF, StallD, StallE, FlushD, FlushE, FlushM,
    input  ForwardAE, ForwardBE, FpBusy, FpDoneE, StallCnt
  );

  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    input  ResultSrcE0, RegWriteM, RegWriteW, PCSrcE, FpMultiE,
    output StallF, StallD, StallE, FlushD, FlushE, FlushM,
    output ForwardAE, ForwardBE, FpBusy, FpDoneE, StallCnt
  );
endinterface

// File: rtl/hazard_ctrl_mc.sv
// Hazard controller for the 5-stage RV32 core: load-use stall, branch flush, EX forwarding
// and an occupancy tracker that holds upstream stages while a multi-cycle FP op sits in EX.
module hazard_ctrl_mc #(
  parameter int unsigned FP_LAT = 4,
  parameter int unsigned CNT_W  = 16
) (
  input logic            clk,
  input logic            reset,
  hazard_ctrl_mc_if.slave hz
);
  localparam int unsigned CntW = (FP_LAT > 1) ? $clog2(FP_LAT) : 1;

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             fp_stall, fp_done, lw_stall, stall_any;

  function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input logic [4:0] rd_m,
                                         input logic wr_m, input logic [4:0] rd_w,
                                         input logic wr_w);
    logic [1:0] sel;
    sel = 2'b00;
    if (wr_m && (rd_m != 5'd0) && (rd_m == rs)) begin
      sel = 2'b10;
    end else if (wr_w && (rd_w != 5'd0) && (rd_w == rs)) begin
      sel = 2'b01;
    end
    return sel;
  endfunction

  // cnt holds the remaining stall cycles after the current one.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    fp_stall = 1'b0;
    fp_done  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (hz.FpMultiE) begin
          if (FP_LAT == 1) begin
            fp_done = 1'b1;
          end else begin
            fp_stall = 1'b1;
            state_d  = StBusy;
            cnt_d    = CntW'(FP_LAT - 2);
          end
        end
      end
      StBusy: begin
        if (cnt_q != '0) begin
          fp_stall = 1'b1;
          cnt_d    = cnt_q - 1'b1;
        end else begin
          fp_done = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    lw_stall = hz.ResultSrcE0 && (hz.RdE != 5'd0) &&
               ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D)) && !fp_stall;
    stall_any = !reset && (lw_stall || fp_stall);

    hz.StallF    = stall_any;
    hz.StallD    = stall_any;
    hz.StallE    = !reset && fp_stall;
    hz.FlushM    = !reset && fp_stall;
    hz.FlushE    = !reset && (lw_stall || hz.PCSrcE) && !fp_stall;
    hz.FlushD    = !reset && hz.PCSrcE && !fp_stall;
    hz.ForwardAE = reset ? 2'b00 : fwd_sel(hz.Rs1E, hz.RdM, hz.RegWriteM, hz.RdW, hz.RegWriteW);
    hz.ForwardBE = reset ? 2'b00 : fwd_sel(hz.Rs2E, hz.RdM, hz.RegWriteM, hz.RdW, hz.RegWriteW);
    hz.FpDoneE   = !reset && fp_done;
    hz.FpBusy    = !reset && (state_q == StBusy);
    hz.StallCnt  = stall_cnt_q;

    stall_cnt_d = stall_cnt_q;
    if (stall_any && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // A taken branch cannot coexist with a held EX stage; FpMultiE must be known when idle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      a_no_branch_in_fp: assert (!(hz.PCSrcE && fp_stall));
      if (state_q == StIdle) begin
        a_fpmulti_known: assert (!$isunknown(hz.FpMultiE));
      end
    end
  end
endmodule

// File: doc/hazard_ctrl_mc.md
Name: hazard_ctrl_mc

Overview:
- Pipeline hazard controller for the 5-stage RV32 core; generates the stall and flush controls consumed by the IF/ID, ID/EX and EX/MEM pipeline registers.
- Combines combinational load-use detection, branch flush and EX-stage forwarding with a sequential occupancy tracker for the multi-cycle FP execute unit.
- Holds upstream stages while an FP op is resident in EX and maintains a saturating stall-cycle performance counter.

Parameters:
- FP_LAT, 4, total EX-stage residency in cycles of a multi-cycle FP op; legal range 1..16.
- CNT_W, 16, width of the stall performance counter.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- Rs1D, Rs2D  in  5 each  source registers of the instruction in ID
- Rs1E, Rs2E, RdE  in  5 each  source and destination registers of the instruction in EX
- RdM, RdW  in  5 each  destination registers in MEM and WB
- ResultSrcE0  in  1  the instruction in EX is a load
- RegWriteM, RegWriteW  in  1 each  register write enables in MEM and WB
- PCSrcE  in  1  branch or jump taken in EX
- FpMultiE  in  1  the instruction in EX is a multi-cycle FP op
- StallF, StallD, StallE  out  1 each  hold the PC, IF/ID and ID/EX registers
- FlushD, FlushE, FlushM  out  1 each  insert a NOP into IF/ID, ID/EX and EX/MEM
- ForwardAE, ForwardBE  out  2 each  operand source select: 00 register file, 01 WB, 10 MEM
- FpBusy  out  1  tracker is in state BUSY
- FpDoneE  out  1  FP result valid this cycle; the op leaves EX at the next edge
- StallCnt  out  CNT_W  saturating count of cycles with StallD=1

Behaviour:
- Reset, synchronous: state=IDLE, cnt=0, StallCnt=0.
- While reset=1, all combinational outputs are forced to 0: Stall*, Flush*, Forward*, FpDoneE.
- FSM states and counter:
  - States are IDLE and BUSY; cnt width is clog2(FP_LAT) with a minimum of 1.
- IDLE behaviour:
  - FpMultiE=0: fpStall=0; no state change.
  - FpMultiE=1 and FP_LAT=1: fpStall=0, FpDoneE=1; stay in IDLE.
  - FpMultiE=1 and FP_LAT>1: fpStall=1; next state BUSY; cnt <= FP_LAT-2.
- BUSY behaviour:
  - cnt!=0: fpStall=1; cnt <= cnt-1.
  - cnt==0: fpStall=0, FpDoneE=1; next state IDLE.
- Residency check: an FP op occupies EX for exactly FP_LAT cycles. A back-to-back FP op entering EX on the cycle after FpDoneE starts a fresh sequence from IDLE.
- FpBusy = (state==BUSY).
- lwStall = ResultSrcE0 & (RdE!=0) & (RdE==Rs1D | RdE==Rs2D) & ~fpStall.
- Stall and flush equations:
  - StallF = StallD = lwStall | fpStall.
  - StallE = fpStall.
  - FlushM = fpStall (bubble into MEM while EX is held).
  - FlushE = (lwStall | PCSrcE) & ~fpStall.
  - FlushD = PCSrcE & ~fpStall.
- Forwarding, per operand X in {A,B} with RsXE:
  - 10 if RegWriteM & RdM!=0 & RdM==RsXE;
  - else 01 if RegWriteW & RdW!=0 & RdW==RsXE;
  - else 00.
  - MEM has priority over WB; x0 is never forwarded.
  - Forwarding stays active during fpStall.
- All stall, flush and forward outputs are combinational from inputs and state; zero added latency.
- FpBusy, and the FpDoneE asserted in BUSY, depend only on registered state.
- StallCnt increments on every non-reset edge where StallD=1 and saturates at 2^CNT_W-1.
- Reset mid-operation (reset high while BUSY): next state is IDLE and all outputs are 0 during reset. The EX op is discarded by the pipeline-register reset.
- PCSrcE=1 while fpStall=1 is illegal; it is ignored (no flush) and an assertion fires in simulation.
- Unknown (X) on FpMultiE while IDLE: assertion.

Test Plan:
- Load-use: ResultSrcE0=1, RdE=5, Rs1D=5 -> StallF=StallD=1, FlushE=1, StallCnt +1; with RdE=0 instead -> no stall.
- Branch: PCSrcE=1 with no load -> FlushD=FlushE=1, StallF=StallD=0 for that cycle only.
- Forwarding: RdM=RdW=7, both RegWrite=1, Rs1E=7 -> ForwardAE=10; RegWriteM=0 -> 01; Rs2E=0 with RdM=0 -> ForwardBE=00.
- FP_LAT=4: FpMultiE high from cycle 0 -> fpStall in cycles 0-2 (StallE=FlushM=1, FpBusy=1 in cycles 1-2), FpDoneE=1 and stalls low in cycle 3, IDLE in cycle 4; back-to-back FP op restarts cleanly.
- FP_LAT=1 and FP_LAT=2 builds: FpDoneE in the entry cycle with no stall; then one stall cycle followed by FpDoneE.
- Reset asserted in cycle 1 of a FP_LAT=4 op -> all outputs 0 during reset, state IDLE, StallCnt=0 after reset; StallCnt saturates at 65535 under forced continuous load-use.
